// File: rtl/issue_queue_pkg.sv
// Shared types and defaults for the in-order issue queue.
package issue_queue_pkg;

  localparam int unsigned IQ_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic        num1_need;
    logic [4:0]  num1_addr;
    logic [31:0] num1;
    logic        num2_need;
    logic [4:0]  num2_addr;
    logic [31:0] num2;
  } issue_queue_element_t;

endpackage

// File: rtl/iq_operand_select.sv
// Resolves one source operand of the head entry: readiness and value.
module iq_operand_select (
  input  logic        need_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] stored_i,
  input  logic [31:0] reg_busy_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic [31:0] rf_rdata_i,
  output logic        ready_o,
  output logic [31:0] value_o
);

  logic wb_hit;

  always_comb begin
    wb_hit  = wb_valid_i && (wb_addr_i == addr_i);
    ready_o = !need_i || (addr_i == 5'd0) || !reg_busy_i[addr_i] || wb_hit;
    // Writeback bypass wins over the register file, which still holds the old value.
    if (!need_i) begin
      value_o = stored_i;
    end else if (addr_i == 5'd0) begin
      value_o = 32'd0;
    end else if (wb_hit) begin
      value_o = wb_data_i;
    end else begin
      value_o = rf_rdata_i;
    end
  end

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: circular FIFO whose head issues once both operands resolve.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 enq_valid,
  input  issue_queue_element_t enq_elem,
  output logic                 enq_ready,
  input  logic [31:0]          reg_busy,
  output logic [4:0]           rf_raddr1,
  output logic [4:0]           rf_raddr2,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_addr,
  input  logic [31:0]          wb_data,
  output logic                 iss_valid,
  output issue_queue_element_t iss_elem,
  input  logic                 iss_ready
);

  localparam int unsigned PtrW = $clog2(IQ_DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(IQ_DEPTH);

  issue_queue_element_t mem_q [IQ_DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]   count_q, count_d;

  issue_queue_element_t head_elem;
  logic        rdy1, rdy2;
  logic [31:0] val1, val2;
  logic        enq_fire, deq_fire;

  assign head_elem = mem_q[head_q];
  assign rf_raddr1 = head_elem.num1_addr;
  assign rf_raddr2 = head_elem.num2_addr;

  iq_operand_select u_sel1 (
    .need_i     (head_elem.num1_need),
    .addr_i     (head_elem.num1_addr),
    .stored_i   (head_elem.num1),
    .reg_busy_i (reg_busy),
    .wb_valid_i (wb_valid),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .rf_rdata_i (rf_rdata1),
    .ready_o    (rdy1),
    .value_o    (val1)
  );

  iq_operand_select u_sel2 (
    .need_i     (head_elem.num2_need),
    .addr_i     (head_elem.num2_addr),
    .stored_i   (head_elem.num2),
    .reg_busy_i (reg_busy),
    .wb_valid_i (wb_valid),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .rf_rdata_i (rf_rdata2),
    .ready_o    (rdy2),
    .value_o    (val2)
  );

  // enq_ready deliberately ignores iss_ready so no dequeue-to-enqueue path exists.
  always_comb begin
    enq_ready = (count_q < DepthCnt) && !rst;
    iss_valid = (count_q != '0) && rdy1 && rdy2 && !flush && !rst;
    enq_fire  = enq_valid && enq_ready && !flush;
    deq_fire  = iss_valid && iss_ready;

    iss_elem           = head_elem;
    iss_elem.num1      = val1;
    iss_elem.num2      = val2;
    iss_elem.num1_need = 1'b0;
    iss_elem.num2_need = 1'b0;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_fire) tail_d = tail_q + PtrW'(1);
    if (deq_fire) head_d = head_q + PtrW'(1);
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[tail_q] <= enq_elem;
  end

endmodule
